// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous RAM between two requesters.
// A requester's transfer is accepted on any rising HCLK edge where its req and gnt
// are both high. Read data returns one cycle later on that requester's rvalid/rdata.
// An owner that holds lock keeps the RAM. A burst limit (MAX_BURST) stops one port
// from starving the other.
// Build option: define RAM_ARB_RR_EN to resolve unlocked contention round-robin.
// Without it, contention uses fixed priority: r0 wins over r1.
module ram_port_arbiter #(
    parameter int AW        = 13,
    parameter int MAX_BURST = 4
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    // requester 0
    input  logic          r0_req,
    input  logic          r0_lock,
    input  logic          r0_we,
    input  logic [3:0]    r0_ben,
    input  logic [AW-3:0] r0_addr,
    input  logic [31:0]   r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [31:0]   r0_rdata,
    // requester 1
    input  logic          r1_req,
    input  logic          r1_lock,
    input  logic          r1_we,
    input  logic [3:0]    r1_ben,
    input  logic [AW-3:0] r1_addr,
    input  logic [31:0]   r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [31:0]   r1_rdata,
    // RAM side
    input  logic [31:0]   DO,
    output logic [31:0]   DI,
    output logic [31:0]   BEN,
    output logic [AW-3:0] AD,
    output logic          EN,
    output logic          R_WB
);

    // Ownership FSM: which requester was granted last (IDLE after a request-free cycle).
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic [1:0] state_q, state_d;
    logic [3:0] burst_q, burst_d;      // consecutive grants to the owner while the other port waits
    logic       rtag_vld_q, rtag_vld_d; // a read was accepted last cycle
    logic       rtag_own_q, rtag_own_d; // which port that read belongs to (1 = r1)
`ifdef RAM_ARB_RR_EN
    logic       last_q, last_d;         // last granted port (1 = r1)
`endif

    logic both_req;
    logic owner_valid;
    logic owner_id;
    logic owner_lock;
    logic burst_done;
    logic pick_r1;
    logic contend_r1;

    // Expand 4 byte enables into a 32-bit bit-mask.
    function automatic logic [31:0] expand_ben(input logic [3:0] b);
        return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    endfunction

    // Unlocked contention choice: round-robin or fixed r0 priority.
`ifdef RAM_ARB_RR_EN
    assign contend_r1 = ~last_q;
`else
    assign contend_r1 = 1'b0;
`endif

    // Grant decision: the sole requester wins. Under contention the order is
    // burst handover first, then the owner's lock, then the contention policy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        r0_gnt      = 1'b0;
        r1_gnt      = 1'b0;
        pick_r1     = 1'b0;
        both_req    = r0_req & r1_req;
        owner_valid = (state_q != ST_IDLE);
        owner_id    = (state_q == ST_OWN1);
        owner_lock  = owner_id ? r1_lock : r0_lock;
        burst_done  = owner_valid && (burst_q >= BURST_MAX);
        if (both_req) begin
            if (burst_done) begin
                pick_r1 = ~owner_id;
            end else if (owner_valid && owner_lock) begin
                pick_r1 = owner_id;
            end else begin
                pick_r1 = contend_r1;
            end
            r0_gnt = ~pick_r1;
            r1_gnt = pick_r1;
        end else begin
            r0_gnt = r0_req;
            r1_gnt = r1_req;
        end
    end

    // RAM command mux: drive the granted port's request; park the bus when idle.
    always_comb begin
        EN   = 1'b0;
        R_WB = 1'b1;
        AD   = '0;
        DI   = '0;
        BEN  = '0;
        if (r0_gnt) begin
            EN   = 1'b1;
            R_WB = ~r0_we;
            AD   = r0_addr;
            DI   = r0_wdata;
            BEN  = r0_we ? expand_ben(r0_ben) : 32'hFFFF_FFFF;
        end else if (r1_gnt) begin
            EN   = 1'b1;
            R_WB = ~r1_we;
            AD   = r1_addr;
            DI   = r1_wdata;
            BEN  = r1_we ? expand_ben(r1_ben) : 32'hFFFF_FFFF;
        end
    end

    // Next-state: ownership, burst count and read tag for the accepted transfer.
    // The burst count includes the grant that starts it, so the handover happens
    // after exactly MAX_BURST consecutive contended grants.
    always_comb begin
        state_d    = ST_IDLE;
        burst_d    = '0;
        rtag_vld_d = (r0_gnt & ~r0_we) | (r1_gnt & ~r1_we);
        rtag_own_d = r1_gnt;
`ifdef RAM_ARB_RR_EN
        last_d     = last_q;
`endif
        if (r0_gnt | r1_gnt) begin
            state_d = r1_gnt ? ST_OWN1 : ST_OWN0;
`ifdef RAM_ARB_RR_EN
            last_d  = r1_gnt;
`endif
            if (!both_req) begin
                burst_d = '0;
            end else if (owner_valid && (owner_id == r1_gnt)) begin
                burst_d = burst_q + 4'd1;
            end else begin
                burst_d = 4'd1;
            end
        end
    end

    // State registers; reset drops any read accepted in the reset cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q    <= ST_IDLE;
            burst_q    <= '0;
            rtag_vld_q <= 1'b0;
            rtag_own_q <= 1'b0;
`ifdef RAM_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            rtag_vld_q <= rtag_vld_d;
            rtag_own_q <= rtag_own_d;
`ifdef RAM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    // Read return: RAM output is routed to the port that issued last cycle's read.
    always_comb begin
        r0_rvalid = rtag_vld_q & ~rtag_own_q;
        r1_rvalid = rtag_vld_q &  rtag_own_q;
        r0_rdata  = r0_rvalid ? DO : 32'h0;
        r1_rdata  = r1_rvalid ? DO : 32'h0;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios plus randomized traffic for ram_port_arbiter.
// The reference model tracks owner, the contended grant count and the last winner
// as plain integers. It derives each cycle's expected grant, RAM command and read return.
module tb_ram_port_arbiter;

    localparam int AW        = 13;
    localparam int MAX_BURST = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          r0_req, r0_lock, r0_we, r1_req, r1_lock, r1_we;
    logic [3:0]    r0_ben, r1_ben;
    logic [AW-3:0] r0_addr, r1_addr;
    logic [31:0]   r0_wdata, r1_wdata;
    logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [31:0]   r0_rdata, r1_rdata;
    logic [31:0]   DO, DI, BEN;
    logic [AW-3:0] AD;
    logic          EN, R_WB;

    ram_port_arbiter #(.AW(AW), .MAX_BURST(MAX_BURST)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_ben(r0_ben),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt),
        .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_ben(r1_ben),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt),
        .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .DO(DO), .DI(DI), .BEN(BEN), .AD(AD), .EN(EN), .R_WB(R_WB)
    );

    always #5 HCLK = ~HCLK;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: owner (-1 none), contended grants so far, last winner,
    // port whose read returns this cycle (-1 none).
    int m_owner, m_cnt, m_last, m_rd;

    int exp25 [8];
    int exp26 [6];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = 1;
        m_rd    = -1;
    endtask

    // Expected winner for the current inputs: -1 none, else port number.
    function automatic int exp_grant();
        logic lk;
        if (!r0_req && !r1_req) return -1;
        if (r0_req != r1_req) return r0_req ? 0 : 1;
        if (m_owner >= 0 && m_cnt >= MAX_BURST) return 1 - m_owner;
        lk = (m_owner == 1) ? r1_lock : r0_lock;
        if (m_owner >= 0 && lk) return m_owner;
`ifdef RAM_ARB_RR_EN
        return 1 - m_last;
`else
        return 0;
`endif
    endfunction

    // Apply request controls; payload fields and RAM read data are randomized.
    task automatic drive(input logic q0, input logic l0, input logic w0,
                         input logic q1, input logic l1, input logic w1);
        r0_req = q0; r0_lock = l0; r0_we = w0;
        r1_req = q1; r1_lock = l1; r1_we = w1;
        r0_ben = 4'($urandom); r1_ben = 4'($urandom);
        r0_addr = (AW-2)'($urandom); r1_addr = (AW-2)'($urandom);
        r0_wdata = $urandom; r1_wdata = $urandom;
        DO = $urandom;
    endtask

    // One clock: check outputs against the model, take the edge, advance the model.
    // Entered just after a falling edge with inputs applied; returns at the next one.
    task automatic cycle(output int obs_g);
        int          g;
        logic        we;
        logic [3:0]  b;
        logic [31:0] eb;
        #1;
        g = exp_grant();
        we = 1'b0;
        obs_g = (r0_gnt && r1_gnt) ? 2 : r0_gnt ? 0 : r1_gnt ? 1 : -1;
        check("gnt", obs_g, g);
        if (g < 0) begin
            check("en_idle", EN, 1'b0);
            check("rwb_idle", R_WB, 1'b1);
            check("ad_idle", AD, 0);
            check("di_idle", DI, 0);
            check("ben_idle", BEN, 0);
        end else begin
            we = (g == 1) ? r1_we : r0_we;
            b  = (g == 1) ? r1_ben : r0_ben;
            for (int i = 0; i < 4; i++) eb[8*i +: 8] = we ? {8{b[i]}} : 8'hFF;
            check("en", EN, 1'b1);
            check("rwb", R_WB, !we);
            check("ad", AD, (g == 1) ? r1_addr : r0_addr);
            check("di", DI, (g == 1) ? r1_wdata : r0_wdata);
            check("ben", BEN, eb);
        end
        check("rv0", r0_rvalid, m_rd == 0);
        check("rv1", r1_rvalid, m_rd == 1);
        check("rd0", r0_rdata, (m_rd == 0) ? DO : 32'h0);
        check("rd1", r1_rdata, (m_rd == 1) ? DO : 32'h0);
        @(posedge HCLK);
        if (g < 0) begin
            m_owner = -1;
            m_cnt   = 0;
            m_rd    = -1;
        end else begin
            if (!(r0_req && r1_req)) m_cnt = 0;
            else if (g == m_owner)   m_cnt = m_cnt + 1;
            else                     m_cnt = 1;
            m_owner = g;
            m_last  = g;
            m_rd    = we ? -1 : g;
        end
        @(negedge HCLK);
    endtask

    initial begin
        int g;
`ifdef RAM_ARB_RR_EN
        exp25 = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp25 = '{0, 0, 0, 0, 1, 0, 0, 0};
`endif
        exp26 = '{0, 0, 0, 0, 1, 0};

        // Reset state with no requests.
        HRESETn = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        DO = 32'hDEADBEEF;
        model_reset();
        repeat (2) @(negedge HCLK);
        #1;
        check("rst_gnt0", r0_gnt, 1'b0);
        check("rst_gnt1", r1_gnt, 1'b0);
        check("rst_en", EN, 1'b0);
        check("rst_rwb", R_WB, 1'b1);
        check("rst_ad", AD, 0);
        check("rst_di", DI, 0);
        check("rst_ben", BEN, 0);
        check("rst_rv0", r0_rvalid, 1'b0);
        check("rst_rv1", r1_rvalid, 1'b0);
        check("rst_rd0", r0_rdata, 0);
        check("rst_rd1", r1_rdata, 0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Single read by r0 and its return one cycle later.
        drive(1, 0, 0, 0, 0, 0);
        r0_addr = 11'h010;
        #1;
        check("t23_gnt0", r0_gnt, 1'b1);
        check("t23_en", EN, 1'b1);
        check("t23_rwb", R_WB, 1'b1);
        check("t23_ad", AD, 11'h010);
        cycle(g);
        drive(0, 0, 0, 0, 0, 0);
        DO = 32'hCAFEF00D;
        #1;
        check("t23_rv0", r0_rvalid, 1'b1);
        check("t23_rd0", r0_rdata, 32'hCAFEF00D);
        check("t23_rd1", r1_rdata, 32'h0);
        cycle(g);

        // Byte-masked write by r1: expanded enables, no read return.
        drive(0, 0, 0, 1, 0, 1);
        r1_addr  = 11'h3FF;
        r1_ben   = 4'b0101;
        r1_wdata = 32'h11223344;
        #1;
        check("t24_ben", BEN, 32'h00FF00FF);
        check("t24_rwb", R_WB, 1'b0);
        check("t24_di", DI, 32'h11223344);
        check("t24_ad", AD, 11'h3FF);
        cycle(g);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("t24_rv0", r0_rvalid, 1'b0);
        check("t24_rv1", r1_rvalid, 1'b0);
        cycle(g);

        // Continuous unlocked contention for 8 cycles.
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 1, 0, 0);
            cycle(g);
            check($sformatf("t25_grant%0d", i), g, exp25[i]);
        end
        drive(0, 0, 0, 0, 0, 0);
        cycle(g);

        // r0 holds lock against a waiting r1: burst limit forces one r1 grant.
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 1, 0, 0);
            cycle(g);
            check($sformatf("t26_grant%0d", i), g, exp26[i]);
        end
        drive(0, 0, 0, 0, 0, 0);
        cycle(g);

        // Back-to-back reads from alternating ports.
        drive(1, 0, 0, 0, 0, 0);
        r0_addr = 11'h001;
        #1;
        check("t27_ad0", AD, 11'h001);
        cycle(g);
        drive(0, 0, 0, 1, 0, 0);
        r1_addr = 11'h002;
        DO = 32'hA5A50001;
        #1;
        check("t27_ad1", AD, 11'h002);
        check("t27_rv0", r0_rvalid, 1'b1);
        check("t27_rd0", r0_rdata, 32'hA5A50001);
        check("t27_rv1_lo", r1_rvalid, 1'b0);
        cycle(g);
        drive(0, 0, 0, 0, 0, 0);
        DO = 32'hA5A50002;
        #1;
        check("t27_rv1", r1_rvalid, 1'b1);
        check("t27_rd1", r1_rdata, 32'hA5A50002);
        check("t27_rv0_lo", r0_rvalid, 1'b0);
        cycle(g);

        // Reset arrives in the cycle of an r0 read grant: that read never returns.
        drive(1, 0, 0, 0, 0, 0);
        #1;
        check("t28_gnt0", r0_gnt, 1'b1);
        #1;
        HRESETn = 1'b0;
        model_reset();
        @(posedge HCLK);
        #1;
        check("t28_rv0_in_rst", r0_rvalid, 1'b0);
        @(negedge HCLK);
        drive(0, 0, 0, 0, 0, 0);
        HRESETn = 1'b1;
        #1;
        check("t28_rv0", r0_rvalid, 1'b0);
        check("t28_en", EN, 1'b0);
        cycle(g);
        drive(1, 0, 0, 1, 0, 0);
        cycle(g);
        check("t28_first_contention", g, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'($urandom));
            cycle(g);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 13, meaning byte-address width; RAM word address is AW-2 bits.
REQ-002 SHALL have parameter MAX_BURST, default 4, meaning max consecutive grants to one requester while the other waits (range 1..15).
REQ-003 SHALL have port HCLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have, for N in {0,1}, ports rN_req  input  1  transfer request; rN_lock  input  1  hold ownership; rN_we  input  1  1=write; rN_ben  input  4  byte enables; rN_addr  input  AW-2  word address; rN_wdata  input  32  write data.
REQ-006 SHALL have, for N in {0,1}, ports rN_gnt  output  1  transfer accepted this cycle; rN_rvalid  output  1  read data valid; rN_rdata  output  32  read data.
REQ-007 SHALL have RAM ports DO  input  32; DI  output  32; BEN  output  32; AD  output  AW-2; EN  output  1; R_WB  output  1 (1=read).

Function
REQ-008 SHALL accept a transfer when rN_req & rN_gnt at a rising edge; rN_gnt is combinational from current req/lock and registered state; at most one gnt high per cycle.
REQ-009 SHALL drive RAM from the granted port in the grant cycle: EN=1, AD=rN_addr, DI=rN_wdata, R_WB=~rN_we, BEN byte i = {8{rN_ben[i]}} for writes, 32'hFFFFFFFF for reads.
REQ-010 SHALL, with no grant, drive EN=0, R_WB=1, AD=0, DI=0, BEN=0.
REQ-011 SHALL keep state FSM IDLE/OWN0/OWN1 = last granted requester; IDLE only after reset or a cycle with no request; OWNn->IDLE when no req; ->OWNm on grant to m.
REQ-012 SHALL grant the sole requester immediately when only one requests, in any state.
REQ-013 SHALL, when the owner asserts req & lock, keep granting the owner (lock) regardless of the other port, subject to REQ-015.
REQ-014 SHALL resolve both-requesting, no-lock cases per REQ-021/REQ-022.
REQ-015 SHALL count consecutive grants to the owner while the other port requests (4-bit burst counter); on reaching MAX_BURST, next cycle grants the other port even if locked, then counter resets to 0.
REQ-016 SHALL reset the burst counter to 0 on owner change, on idle cycles, and whenever the other port is not requesting.
REQ-017 SHALL assert rN_rvalid exactly one cycle after port N's read grant, with rN_rdata=DO; rN_rdata SHALL be 0 when rN_rvalid=0.
REQ-018 SHALL support back-to-back reads alternating ports, each rvalid routed to the correct port via a registered read-owner tag; writes produce no rvalid.
REQ-019 SHALL never issue a RAM access with EN=1 unless a requester is granted.

Reset
REQ-020 SHALL on HRESETn=0 asynchronously force FSM=IDLE, burst counter=0, last-granted=1, read tag invalid, r0_rvalid=r1_rvalid=0, r0_rdata=r1_rdata=0; combinational gnt/RAM outputs follow REQ-010 unless requests present after release; a read granted in the cycle reset asserts SHALL produce no rvalid.

Configuration
REQ-021 SHALL, with macro RAM_ARB_RR_EN defined, resolve unlocked contention round-robin: grant the port not granted last (port 0 first after reset).
REQ-022 SHALL, without RAM_ARB_RR_EN, resolve unlocked contention with fixed priority r0 > r1, r1 protected only by REQ-015.

Verification
REQ-023 SHALL cover: r0 read addr 0x010 alone, DO=0xCAFEF00D -> r0_gnt same cycle, EN=1,R_WB=1,AD=0x010; next cycle r0_rvalid=1,r0_rdata=0xCAFEF00D, r1_rdata=0.
REQ-024 SHALL cover: r1 write addr 0x3FF, ben=4'b0101, wdata=0x11223344 -> BEN=0x00FF00FF, R_WB=0, DI=0x11223344, no rvalid.
REQ-025 SHALL cover: both request continuously 8 cycles unlocked -> with RAM_ARB_RR_EN grants 0,1,0,1,...; without, grants 0,0,0,0,1,0,0,0 (MAX_BURST=4).
REQ-026 SHALL cover: r0 req&lock, r1 req, MAX_BURST=4 -> r0 granted 4 cycles, r1 granted cycle 5, r0 resumes cycle 6.
REQ-027 SHALL cover: alternating reads r0@0x001, r1@0x002 back-to-back -> rvalid on r0 then r1, each with DO of its cycle.
REQ-028 SHALL cover: HRESETn low mid-cycle after r0 read grant -> r0_rvalid stays 0, FSM IDLE, next RR contention grants r0.
